// File: rtl/cabac_pkg.sv
// rtl/cabac_pkg.sv - shared CABAC context-RAM types and default widths
// Contents: CTX_DATA_W / CTX_ADDR_W default widths, init_state_t sweep FSM encoding.
package cabac_pkg;

  localparam int CTX_DATA_W = 7;  // 6-bit pStateIdx + 1-bit valMps
  localparam int CTX_ADDR_W = 6;  // 64 contexts per table

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } init_state_t;

endpackage

// File: rtl/rf_2p.sv
// rtl/rf_2p.sv - two-port register file, port A synchronous read, port B write
// Ports:
//   clka_i, cena_i (active-low), addra_i -> dataa_o : read port, data one cycle after enable
//   clkb_i, cenb_i (active-low), addrb_i, datab_i   : write port
// Storage is not reset. A same-address read and write in one cycle returns the old word.
module rf_2p #(
  parameter int Addr_Width = 6,
  parameter int Word_Width = 7
) (
  input  logic                  clka_i,
  input  logic                  cena_i,
  input  logic [Addr_Width-1:0] addra_i,
  output logic [Word_Width-1:0] dataa_o,
  input  logic                  clkb_i,
  input  logic                  cenb_i,
  input  logic [Addr_Width-1:0] addrb_i,
  input  logic [Word_Width-1:0] datab_i
);

  localparam int DEPTH = 1 << Addr_Width;

  logic [Word_Width-1:0] mem [DEPTH];

  always_ff @(posedge clka_i) begin
    if (!cena_i) begin
      dataa_o <= mem[addra_i];
    end
  end

  always_ff @(posedge clkb_i) begin
    if (!cenb_i) begin
      mem[addrb_i] <= datab_i;
    end
  end

endmodule

// File: rtl/cabac_ctx_state_ram.sv
// rtl/cabac_ctx_state_ram.sv - CABAC context state RAM with init sweep and write-first forwarding
// Ports:
//   clk, rst (sync, active-high)
//   init_start -> sweep request; init_addr/init_data : external init table lookup;
//   init_busy : sweep in progress; init_done : one-cycle pulse after the last word
//   r_en, r_addr -> r_valid, r_data : 1-cycle read, r_data is 0 when r_valid is 0
//   w_en, w_addr, w_data : write port, ignored during a sweep
module cabac_ctx_state_ram
  import cabac_pkg::*;
#(
  parameter int DATA_W = CTX_DATA_W,
  parameter int ADDR_W = CTX_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_start,
  output logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_busy,
  output logic              init_done,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              r_valid,
  output logic [DATA_W-1:0] r_data,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  init_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic              done_nxt;

  logic              idle;
  logic              rd_acc;
  logic              wr_acc;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0] ram_q;
  logic              cena;
  logic              cenb;
  logic [ADDR_W-1:0] addrb;
  logic [DATA_W-1:0] datab;

  assign idle      = (state == ST_IDLE);
  assign init_busy = (state == ST_INIT);
  assign rd_acc    = idle & r_en;
  assign wr_acc    = idle & w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_addr <= addr_nxt;
      init_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = init_addr;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_start) begin
          state_nxt = ST_INIT;
          addr_nxt  = '0;
        end
      end
      ST_INIT: begin
        // init_start is not looked at here, so a sweep can be neither restarted nor stretched
        if (init_addr == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          addr_nxt  = '0;
          done_nxt  = 1'b1;
        end else begin
          addr_nxt = init_addr + ADDR_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        addr_nxt  = '0;
      end
    endcase
  end

  // The RAM returns the pre-write word on a same-cycle collision, so the
  // collision is remembered and the write data substituted one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      r_valid  <= rd_acc;
      fwd_hit  <= rd_acc & wr_acc & (r_addr == w_addr);
      fwd_data <= w_data;
    end
  end

  assign r_data = !r_valid ? '0 : (fwd_hit ? fwd_data : ram_q);

  // Port B is owned by the sweep while busy; user writes only land in IDLE.
  assign cena  = ~rd_acc;
  assign cenb  = ~((init_busy | wr_acc) & ~rst);
  assign addrb = init_busy ? init_addr : w_addr;
  assign datab = init_busy ? init_data : w_data;

  rf_2p #(
    .Addr_Width(ADDR_W),
    .Word_Width(DATA_W)
  ) u_rf (
    .clka_i (clk),
    .cena_i (cena),
    .addra_i(r_addr),
    .dataa_o(ram_q),
    .clkb_i (clk),
    .cenb_i (cenb),
    .addrb_i(addrb),
    .datab_i(datab)
  );

endmodule

// File: tb/tb_cabac_ctx_state_ram.sv
// tb/tb_cabac_ctx_state_ram.sv - self-checking bench for cabac_ctx_state_ram
module tb_cabac_ctx_state_ram;

  logic clk;
  logic rst;

  // default-width instance (7-bit words, 64 deep)
  logic       init_start0, init_busy0, init_done0;
  logic [5:0] init_addr0;
  logic [6:0] init_data0;
  logic       r_en0, r_valid0, w_en0;
  logic [5:0] r_addr0, w_addr0;
  logic [6:0] r_data0, w_data0;

  // parameter-variant instance (9-bit words, 16 deep)
  logic       init_start1, init_busy1, init_done1;
  logic [3:0] init_addr1;
  logic [8:0] init_data1;
  logic       r_en1, r_valid1, w_en1;
  logic [3:0] r_addr1, w_addr1;
  logic [8:0] r_data1, w_data1;

  int n_cmp;
  int n_err;

  logic [6:0] m0 [64];
  logic [8:0] m1 [16];

  // external init tables
  assign init_data0 = {1'b0, init_addr0} ^ 7'h2A;
  assign init_data1 = {1'b1, init_addr1, ~init_addr1};

  cabac_ctx_state_ram dut0 (
    .clk(clk), .rst(rst), .init_start(init_start0), .init_addr(init_addr0),
    .init_data(init_data0), .init_busy(init_busy0), .init_done(init_done0),
    .r_en(r_en0), .r_addr(r_addr0), .r_valid(r_valid0), .r_data(r_data0),
    .w_en(w_en0), .w_addr(w_addr0), .w_data(w_data0)
  );

  cabac_ctx_state_ram #(.DATA_W(9), .ADDR_W(4)) dut1 (
    .clk(clk), .rst(rst), .init_start(init_start1), .init_addr(init_addr1),
    .init_data(init_data1), .init_busy(init_busy1), .init_done(init_done1),
    .r_en(r_en1), .r_addr(r_addr1), .r_valid(r_valid1), .r_data(r_data1),
    .w_en(w_en1), .w_addr(w_addr1), .w_data(w_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         re;
    logic [5:0] ra;
    bit         we;
    logic [5:0] wa;
    logic [6:0] wd;
    bit         ev;
    logic [6:0] ed;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep0(input bit poke);
    int cyc;
    int busy_cnt;
    int done_at;
    int rv_cnt;
    init_start0 = 1'b1;
    step();
    init_start0 = 1'b0;
    cyc = 1; busy_cnt = 0; done_at = 0; rv_cnt = 0;
    while (done_at == 0 && cyc < 200) begin
      if (init_busy0) busy_cnt++;
      if (r_valid0) rv_cnt++;
      if (init_done0) begin
        done_at = cyc;
      end else begin
        r_en0 = poke && (cyc == 5);
        w_en0 = poke && (cyc == 5);
        r_addr0 = 6'd3; w_addr0 = 6'd3; w_data0 = 7'h7F;
        init_start0 = poke && (cyc == 30);
        step();
        cyc++;
      end
    end
    r_en0 = 1'b0; w_en0 = 1'b0; init_start0 = 1'b0;
    check("sweep0_busy_cycles", busy_cnt, 64);
    check("sweep0_done_cycle", done_at, 65);
    check("sweep0_rvalid_quiet", rv_cnt, 0);
    check("sweep0_done_busy_low", int'(init_busy0), 0);
    check("sweep0_done_addr_zero", int'(init_addr0), 0);
    step();
    check("sweep0_done_one_cycle", int'(init_done0), 0);
    for (int a = 0; a < 64; a++) m0[a] = 7'(a) ^ 7'h2A;
  endtask

  task automatic readback0(input string name);
    for (int a = 0; a < 64; a++) begin
      r_en0 = 1'b1;
      r_addr0 = 6'(a);
      step();
      check({name, "_valid"}, int'(r_valid0), 1);
      check({name, "_data"}, int'(r_data0), int'(m0[a]));
    end
    r_en0 = 1'b0;
  endtask

  task automatic readback1(input string name);
    for (int a = 0; a < 16; a++) begin
      r_en1 = 1'b1;
      r_addr1 = 4'(a);
      step();
      check({name, "_valid"}, int'(r_valid1), 1);
      check({name, "_data"}, int'(r_data1), int'(m1[a]));
    end
    r_en1 = 1'b0;
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int done_at;
    int done_cnt;
    logic [6:0] exp;

    n_cmp = 0; n_err = 0;
    rst = 1'b1;
    init_start0 = 0; r_en0 = 0; w_en0 = 0; r_addr0 = 0; w_addr0 = 0; w_data0 = 0;
    init_start1 = 0; r_en1 = 0; w_en1 = 0; r_addr1 = 0; w_addr1 = 0; w_data1 = 0;
    for (int i = 0; i < 3; i++) step();

    check("rst_busy", int'(init_busy0), 0);
    check("rst_done", int'(init_done0), 0);
    check("rst_addr", int'(init_addr0), 0);
    check("rst_rvalid", int'(r_valid0), 0);
    check("rst_rdata", int'(r_data0), 0);
    check("rst_busy_p", int'(init_busy1), 0);
    rst = 1'b0;
    step();

    // full sweep with write/read/restart attempts injected mid-sweep
    run_sweep0(1'b1);
    readback0("init_read");

    tbl[0]  = '{0, 6'd0,  1, 6'd10, 7'h55, 0, 7'h00};
    tbl[1]  = '{1, 6'd10, 0, 6'd0,  7'h00, 1, 7'h55};
    tbl[2]  = '{0, 6'd0,  1, 6'd5,  7'h11, 0, 7'h00};
    tbl[3]  = '{1, 6'd5,  1, 6'd5,  7'h33, 1, 7'h33};
    tbl[4]  = '{1, 6'd5,  0, 6'd0,  7'h00, 1, 7'h33};
    tbl[5]  = '{1, 6'd3,  0, 6'd0,  7'h00, 1, 7'h29};
    tbl[6]  = '{1, 6'd62, 1, 6'd63, 7'h7F, 1, 7'h14};
    tbl[7]  = '{1, 6'd63, 0, 6'd0,  7'h00, 1, 7'h7F};
    tbl[8]  = '{0, 6'd0,  1, 6'd0,  7'h01, 0, 7'h00};
    tbl[9]  = '{1, 6'd0,  1, 6'd1,  7'h02, 1, 7'h01};
    tbl[10] = '{1, 6'd1,  0, 6'd0,  7'h00, 1, 7'h02};

    for (int i = 0; i < 11; i++) begin
      r_en0 = tbl[i].re; r_addr0 = tbl[i].ra;
      w_en0 = tbl[i].we; w_addr0 = tbl[i].wa; w_data0 = tbl[i].wd;
      step();
      check($sformatf("vec%0d_valid", i), int'(r_valid0), int'(tbl[i].ev));
      check($sformatf("vec%0d_data", i), int'(r_data0), int'(tbl[i].ed));
      if (tbl[i].we) m0[tbl[i].wa] = tbl[i].wd;
    end
    r_en0 = 0; w_en0 = 0;

    // random traffic against an array model with write-first collisions
    for (int i = 0; i < 300; i++) begin
      r_en0 = 1'($urandom_range(0, 1));
      w_en0 = 1'($urandom_range(0, 1));
      r_addr0 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      w_addr0 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 3)) : 6'($urandom_range(0, 63));
      w_data0 = 7'($urandom);
      exp = (w_en0 && w_addr0 == r_addr0) ? w_data0 : m0[r_addr0];
      step();
      check("rnd_valid", int'(r_valid0), int'(r_en0));
      check("rnd_data", int'(r_data0), r_en0 ? int'(exp) : 0);
      if (w_en0) m0[w_addr0] = w_data0;
    end
    r_en0 = 0; w_en0 = 0;
    step();

    // read in the init_start cycle is served; sweep then aborted by reset at cycle 20
    r_en0 = 1'b1; r_addr0 = 6'd10;
    exp = m0[10];
    init_start0 = 1'b1;
    step();
    init_start0 = 1'b0; r_en0 = 1'b0;
    check("start_cycle_read_valid", int'(r_valid0), 1);
    check("start_cycle_read_data", int'(r_data0), int'(exp));
    for (int c = 1; c < 20; c++) step();
    check("abort_busy_before", int'(init_busy0), 1);
    rst = 1'b1;
    step();
    check("abort_busy", int'(init_busy0), 0);
    check("abort_done", int'(init_done0), 0);
    check("abort_addr", int'(init_addr0), 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      if (init_done0 || init_busy0) done_cnt++;
      step();
    end
    check("abort_stays_idle", done_cnt, 0);
    run_sweep0(1'b0);
    readback0("reinit_read");

    // parameter variant: 16-deep sweep of 9-bit words
    init_start1 = 1'b1;
    step();
    init_start1 = 1'b0;
    cyc = 1; busy_cnt = 0; done_at = 0;
    while (done_at == 0 && cyc < 100) begin
      if (init_busy1) busy_cnt++;
      if (init_done1) begin
        done_at = cyc;
      end else begin
        step();
        cyc++;
      end
    end
    check("sweep1_busy_cycles", busy_cnt, 16);
    check("sweep1_done_cycle", done_at, 17);
    step();
    check("sweep1_done_one_cycle", int'(init_done1), 0);
    for (int a = 0; a < 16; a++) m1[a] = {1'b1, 4'(a), ~4'(a)};
    readback1("p_read");

    // reset leaves the array untouched
    rst = 1'b1;
    step();
    check("p_rst_rvalid", int'(r_valid1), 0);
    check("p_rst_rdata", int'(r_data1), 0);
    step();
    rst = 1'b0;
    step();
    readback1("p_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cabac_ctx_state_ram.md
CABAC_CTX_STATE_RAM -- requirements
Module: cabac_ctx_state_ram

Interface
REQ-001 Parameter DATA_W, default 7, width of one context state word (6-bit pStateIdx + 1-bit valMps).
REQ-002 Parameter ADDR_W, default 6, address width; DEPTH = 2^ADDR_W words.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 init_start  in  1  one-cycle pulse that requests a full-table initialisation sweep.
REQ-006 init_addr  out  ADDR_W  address currently being initialised; indexes the external combinational init-value table.
REQ-007 init_data  in  DATA_W  init value for init_addr, valid in the same cycle.
REQ-008 init_busy  out  1  high while a sweep is in progress.
REQ-009 init_done  out  1  one-cycle pulse after the last word is written.
REQ-010 r_en  in  1  read request; r_addr  in  ADDR_W  read address.
REQ-011 r_valid  out  1  high exactly one cycle after an accepted read; r_data  out  DATA_W  read result.
REQ-012 w_en  in  1  write request; w_addr  in  ADDR_W  write address; w_data  in  DATA_W  write data.

Function
REQ-013 FSM states IDLE and INIT only; reset enters IDLE.
REQ-014 IDLE -> INIT on init_start; init_addr loads 0; init_busy rises in the next cycle.
REQ-015 In INIT, each cycle writes init_data to init_addr, then init_addr increments by 1.
REQ-016 When init_addr = DEPTH-1 is written: INIT -> IDLE, init_done pulses for 1 cycle, init_busy falls, init_addr returns to 0.
REQ-017 Sweep length is exactly DEPTH cycles; init_start during INIT is ignored (no restart, no extension).
REQ-018 In IDLE, r_en accepted every cycle; read latency 1 cycle: r_valid=1 and r_data=mem[r_addr] on the next cycle.
REQ-019 In IDLE, w_en writes w_data to w_addr at the clock edge; one read and one write may issue in the same cycle.
REQ-020 Same-cycle collision (r_en, w_en, r_addr = w_addr): read returns the new w_data (write-first forwarding).
REQ-021 Read issued the cycle after a write to the same address returns the written value without stall.
REQ-022 In INIT, r_en and w_en are ignored: no write occurs and r_valid stays 0.
REQ-023 Reads issued in the same cycle as init_start are still served; writes in that cycle still occur, then are overwritten by the sweep.
REQ-024 r_data SHALL be 0 whenever r_valid = 0.
REQ-025 Addresses wrap naturally at ADDR_W bits; no out-of-range condition exists.

Reset
REQ-026 While rst = 1: FSM = IDLE, init_addr = 0, init_busy = 0, init_done = 0, r_valid = 0, r_data = 0, and the forwarding register is cleared.
REQ-027 rst during INIT aborts the sweep immediately; memory contents are undefined until the next completed sweep.
REQ-028 Reset does not clear the storage array; init_start is the only way to initialise it.

Structure
REQ-029 Storage is one instance of rf_2p (Addr_Width = ADDR_W, Word_Width = DATA_W); port A reads, port B writes; enables are active-low, as rf_2p defines them.
REQ-030 The port-B write mux selects between the init path and the user write path; forwarding uses a registered collision flag and a registered copy of w_data placed after dataa_o.
REQ-031 FSM state encodings and the default DATA_W and ADDR_W live in the shared package cabac_pkg; no other sub-module is used.

Verification
REQ-032 Reset, then init_start with init_data = init_addr ^ 7'h2A -> 64 cycles of init_busy, init_done pulse at cycle 65, reads of addr 0..63 return addr ^ 7'h2A.
REQ-033 IDLE: write 7'h55 to addr 10, next cycle read addr 10 -> r_valid=1 with r_data = 7'h55 one cycle later.
REQ-034 Same cycle: r_en and w_en both at addr 5, w_data = 7'h33, old value 7'h11 -> r_data = 7'h33.
REQ-035 During INIT, drive w_en to addr 3 with 7'h7F and r_en -> r_valid stays 0; after the sweep, addr 3 holds its init value.
REQ-036 Assert rst at sweep cycle 20 -> the next cycle shows init_busy = 0 and no init_done; a new init_start then completes in 64 cycles.
REQ-037 Parameter run with DATA_W = 9 and ADDR_W = 4 -> sweep takes 16 cycles and all 9-bit values read back correctly.
